neuron_mac_accumulator: RTL
===========================

// Module: neuron_mac_accumulator
// PURPOSE
//   Per-neuron multiply-accumulate stage of a dense layer. Consumes a stream
//   of signed (data, weight) fixed-point pairs and accumulates NUM_INPUTS
//   products into one wide signed sum. It presents that sum, with a
//   valid/ready handshake, to the downstream overflow/underflow rectifier,
//   which narrows it to DATA_WIDTH. This block does no saturation.
// PARAMETERS
//   DATA_WIDTH = 16   width of data_in, weight_in, bias_in (signed, Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS)
//   FRAC_BITS  = 8    fractional bits; a product is arithmetic-shifted right by FRAC_BITS
//   ACC_WIDTH  = 32   accumulator/sum width; must satisfy ACC_WIDTH >= 2*DATA_WIDTH-FRAC_BITS
//   NUM_INPUTS = 784  pairs per neuron evaluation; must be >= 1
// PORTS
//   clk_in         in   1                    clock, rising edge
//   rst_n_in       in   1                    reset, asynchronous, active-low
//   clear_in       in   1                    synchronous abort/restart of current vector
//   data_in        in   DATA_WIDTH           signed activation
//   weight_in      in   DATA_WIDTH           signed weight
//   bias_in        in   DATA_WIDTH           signed bias (used only with NEURON_BIAS_EN)
//   in_valid_in    in   1                    data_in/weight_in valid
//   in_ready_out   out  1                    block accepts a pair (registered)
//   sum_out        out  ACC_WIDTH            signed accumulated sum
//   sum_valid_out  out  1                    sum_out valid
//   sum_ready_in   in   1                    downstream consumes sum_out
//   count_out      out  $clog2(NUM_INPUTS+1) pairs accepted in current vector
// BEHAVIOUR
//   - Reset values: in_ready_out=0, sum_valid_out=0, sum_out=0, count_out=0.
//     Internal state: ACCUM, product_valid=0.
//   - in_ready_out goes 1 on the first edge after reset release.
//   - Accept: a pair is accepted on an edge where in_valid_in && in_ready_out.
//     Gaps in in_valid_in are allowed; nothing is accepted while in_ready_out=0.
//   - Pipeline stage 1: on accept, product_r <= sext((data*weight) >>> FRAC_BITS)
//     to ACC_WIDTH; product_valid <= 1. The multiply is full 2*DATA_WIDTH signed.
//   - Pipeline stage 2: if product_valid, acc <= acc + product_r, modulo 2^ACC_WIDTH.
//     Wrap is silent and is not flagged.
//   - FSM states:
//     ACCUM: in_ready=1. Accepting pair NUM_INPUTS-1 -> DRAIN, in_ready<=0.
//     DRAIN: adds the last product -> BIAS (if enabled) else DONE.
//     BIAS:  acc <= acc + sext(bias_in), with bias_in sampled this cycle -> DONE.
//     DONE:  sum_valid_out=1. sum_out=acc, held stable until sum_ready_in.
//   - Consume: an edge in DONE with sum_ready_in -> acc=0, count=0, sum_valid<=0,
//     in_ready<=1, state ACCUM. sum_ready_in is ignored outside DONE.
//   - Latency: sum_valid_out is 1 two edges after the last accept (three with bias).
//     Back-to-back vectors lose exactly one cycle, the consume edge.
//   - clear_in has the highest synchronous priority. It overrides a simultaneous
//     accept or consume and applies the consume-edge values: acc=0, count=0,
//     product_valid=0, sum_valid=0, in_ready=1, state ACCUM.
//   - Async reset mid-vector: all state returns to reset values immediately.
//     The partial sum is discarded.
//   - count_out increments on each accept. It holds NUM_INPUTS from DRAIN
//     through DONE.
// CONFIGURATION
//   NEURON_BIAS_EN defined: the BIAS state is present; sum = sum(products) + sext(bias_in).
//   Undefined: there is no BIAS state, bias_in is unused, and DRAIN goes directly to DONE.
// TESTING  (bench overrides NUM_INPUTS=4, FRAC_BITS=8, DATA_WIDTH=16, ACC_WIDTH=32)
//   - Reset held 5 cycles -> in_ready_out=0, sum_valid_out=0, sum_out=0.
//     After release -> in_ready_out=1 on the next edge.
//   - 4 pairs (0x0100,0x0200) back-to-back, no bias -> sum_out=0x0000_0800.
//     sum_valid_out is 1 two edges after the 4th accept.
//   - 4 pairs (0xFF00,0x0300) with random in_valid gaps -> sum_out=0xFFFF_F400.
//     count_out reads 4 in DONE.
//   - sum_ready_in low for 10 cycles in DONE, new pairs driven -> sum_out and
//     sum_valid_out stay stable and no pair is accepted. sum_ready pulse ->
//     in_ready_out=1 on the next edge.
//   - clear_in after 2 accepted pairs, then 4 pairs of (0x0100,0x0100) ->
//     sum_out=0x0000_0400, with no residue from the aborted vector.
//   - NEURON_BIAS_EN with bias_in=0x0080 and the pairs from the second scenario ->
//     sum_out=0x0000_0880, valid three edges after the last accept.

Source files
------------

// File: rtl/neuron_mac_accumulator.sv
`default_nettype none
// ============================================================================
// Module : neuron_mac_accumulator
// Desc   : Signed fixed-point multiply-accumulate over NUM_INPUTS (data, weight)
//          pairs with a valid/ready wide-sum output. Define NEURON_BIAS_EN to
//          add sext(bias_in) once per vector before the sum is presented.
// Rev    : 1.0  initial release
// ============================================================================
module neuron_mac_accumulator #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int NUM_INPUTS = 784
) (
  input  logic                              clk_in,
  input  logic                              rst_n_in,
  input  logic                              clear_in,
  input  logic [DATA_WIDTH-1:0]             data_in,
  input  logic [DATA_WIDTH-1:0]             weight_in,
  input  logic [DATA_WIDTH-1:0]             bias_in,
  input  logic                              in_valid_in,
  output logic                              in_ready_out,
  output logic [ACC_WIDTH-1:0]              sum_out,
  output logic                              sum_valid_out,
  input  logic                              sum_ready_in,
  output logic [$clog2(NUM_INPUTS+1)-1:0]   count_out
);

  localparam int CW = $clog2(NUM_INPUTS + 1);
  localparam int PW = 2 * DATA_WIDTH;

`ifdef NEURON_BIAS_EN
  typedef enum logic [1:0] {
    S_ACCUM = 2'd0,
    S_DRAIN = 2'd1,
    S_BIAS  = 2'd2,
    S_DONE  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_ACCUM = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd3
  } state_t;
`endif

  state_t                 r_state;
  logic                   r_in_ready;
  logic                   r_sum_valid;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic [CW-1:0]          r_count;
  logic [ACC_WIDTH-1:0]   r_product;
  logic                   r_product_valid;

  logic signed [PW-1:0]   w_prod;
  logic signed [PW-1:0]   w_prod_shr;
  logic [ACC_WIDTH-1:0]   w_product;
  logic                   w_accept;
  logic                   w_last;

  assign w_prod     = $signed(data_in) * $signed(weight_in);
  assign w_prod_shr = w_prod >>> FRAC_BITS;

  // Shifted product fits in ACC_WIDTH by construction; only the sign needs care.
  if (ACC_WIDTH > PW) begin : g_prod_sext
    assign w_product = {{(ACC_WIDTH-PW){w_prod_shr[PW-1]}}, w_prod_shr};
  end else if (ACC_WIDTH == PW) begin : g_prod_same
    assign w_product = w_prod_shr;
  end else begin : g_prod_trunc
    assign w_product = w_prod_shr[ACC_WIDTH-1:0];
  end

`ifdef NEURON_BIAS_EN
  logic [ACC_WIDTH-1:0] w_bias_ext;
  assign w_bias_ext = {{(ACC_WIDTH-DATA_WIDTH){bias_in[DATA_WIDTH-1]}}, bias_in};
`else
  logic w_unused_bias;
  assign w_unused_bias = ^bias_in;
`endif

  assign w_accept = in_valid_in && r_in_ready;
  assign w_last   = (r_count == CW'(NUM_INPUTS - 1));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state         <= S_ACCUM;
      r_in_ready      <= 1'b0;
      r_sum_valid     <= 1'b0;
      r_acc           <= '0;
      r_count         <= '0;
      r_product       <= '0;
      r_product_valid <= 1'b0;
    end else if (clear_in) begin
      r_state         <= S_ACCUM;
      r_in_ready      <= 1'b1;
      r_sum_valid     <= 1'b0;
      r_acc           <= '0;
      r_count         <= '0;
      r_product_valid <= 1'b0;
    end else begin
      r_product_valid <= w_accept;
      if (w_accept) begin
        r_product <= w_product;
        r_count   <= r_count + CW'(1);
      end
      if (r_product_valid) begin
        r_acc <= r_acc + r_product;
      end
      case (r_state)
        S_ACCUM: begin
          if (w_accept && w_last) begin
            r_in_ready <= 1'b0;
            r_state    <= S_DRAIN;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        S_DRAIN: begin
`ifdef NEURON_BIAS_EN
          r_state     <= S_BIAS;
`else
          r_state     <= S_DONE;
          r_sum_valid <= 1'b1;
`endif
        end
`ifdef NEURON_BIAS_EN
        // No product is in flight here, so this add cannot collide with stage 2.
        S_BIAS: begin
          r_acc       <= r_acc + w_bias_ext;
          r_state     <= S_DONE;
          r_sum_valid <= 1'b1;
        end
`endif
        S_DONE: begin
          if (sum_ready_in) begin
            r_acc       <= '0;
            r_count     <= '0;
            r_sum_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_ACCUM;
          end
        end
        default: r_state <= S_ACCUM;
      endcase
    end
  end

  assign in_ready_out  = r_in_ready;
  assign sum_out       = r_acc;
  assign sum_valid_out = r_sum_valid;
  assign count_out     = r_count;

endmodule
`default_nettype wire
